// File: rtl/rr_prio_encoder.sv
// Registered N-input priority encoder with run-time fixed-priority or
// round-robin arbitration; outputs appear one cycle after an enabled sample.
module rr_prio_encoder #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] Din,
    output logic [W-1:0] Dout,
    output logic [N-1:0] grant,
    output logic         valid,
    output logic         multi
);

    // Ascending circular search from start; first set bit wins.
    function automatic logic [W-1:0] f_search(input logic [N-1:0] req,
                                               input logic [W-1:0] start);
        int   idx;
        logic found;
        f_search = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                f_search = W'(idx);
            end
        end
    endfunction

    logic [W-1:0] r_ptr;
    logic [W-1:0] r_dout;
    logic [N-1:0] r_grant;
    logic         r_valid;
    logic         r_multi;

    logic [W-1:0] w_start;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_ptr_next;
    logic [N-1:0] w_grant;
    logic         w_any;
    logic         w_multi;

    always_comb begin
        w_start    = mode ? r_ptr : '0;
        w_idx      = f_search(Din, w_start);
        w_grant    = N'(1) << w_idx;
        w_any      = (Din != '0);
        // Clearing the lowest set bit leaves something only if two or more were set.
        w_multi    = ((Din & (Din - N'(1))) != '0);
        // Explicit wrap so non-power-of-2 N never lands on N.
        w_ptr_next = (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_dout  <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else if (en) begin
            if (w_any) begin
                r_dout  <= w_idx;
                r_grant <= w_grant;
                r_valid <= 1'b1;
                r_multi <= w_multi;
                if (mode) r_ptr <= w_ptr_next;
            end else begin
                r_dout  <= '0;
                r_grant <= '0;
                r_valid <= 1'b0;
                r_multi <= 1'b0;
            end
        end
    end

    assign Dout  = r_dout;
    assign grant = r_grant;
    assign valid = r_valid;
    assign multi = r_multi;

endmodule
